// File: rtl/id_pkg.sv
// id_pkg: shared opcodes, branch kinds and bus layouts for the decode/operand stage
package id_pkg;
  localparam int XLEN = 32;
  localparam int REG_W = 5;
  localparam int IF_TO_ID_W = 97;
  localparam int BP_UPD_W = 67;
  localparam int IB_INST_LSB = 0;
  localparam int IB_PC_LSB = 32;
  localparam int IB_NPC_LSB = 64;
  localparam int IB_PRED_TAKEN = 96;
  localparam int FWD_RD_W = 5;
  localparam int FWD_DATA_W = 32;
  localparam logic [16:0] OP_ADD_W = 17'h00020;
  localparam logic [16:0] OP_SUB_W = 17'h00022;
  localparam logic [16:0] OP_SLT = 17'h00024;
  localparam logic [16:0] OP_SLTU = 17'h00025;
  localparam logic [16:0] OP_NOR = 17'h00028;
  localparam logic [16:0] OP_AND = 17'h00029;
  localparam logic [16:0] OP_OR = 17'h0002a;
  localparam logic [16:0] OP_XOR = 17'h0002b;
  localparam logic [16:0] OP_SLL_W = 17'h0002e;
  localparam logic [16:0] OP_SRL_W = 17'h0002f;
  localparam logic [16:0] OP_SRA_W = 17'h00030;
  localparam logic [16:0] OP_MUL_W = 17'h00038;
  localparam logic [16:0] OP_MULH_W = 17'h00039;
  localparam logic [16:0] OP_MULH_WU = 17'h0003a;
  localparam logic [16:0] OP_DIV_W = 17'h00040;
  localparam logic [16:0] OP_MOD_W = 17'h00041;
  localparam logic [16:0] OP_DIV_WU = 17'h00042;
  localparam logic [16:0] OP_MOD_WU = 17'h00043;
  localparam logic [16:0] OP_SLLI_W = 17'h00081;
  localparam logic [16:0] OP_SRLI_W = 17'h00089;
  localparam logic [16:0] OP_SRAI_W = 17'h00091;
  localparam logic [9:0] OP_SLTI = 10'h008;
  localparam logic [9:0] OP_SLTUI = 10'h009;
  localparam logic [9:0] OP_ADDI_W = 10'h00a;
  localparam logic [9:0] OP_ANDI = 10'h00d;
  localparam logic [9:0] OP_ORI = 10'h00e;
  localparam logic [9:0] OP_XORI = 10'h00f;
  localparam logic [9:0] OP_LD_B = 10'h0a0;
  localparam logic [9:0] OP_LD_H = 10'h0a1;
  localparam logic [9:0] OP_LD_W = 10'h0a2;
  localparam logic [9:0] OP_ST_B = 10'h0a4;
  localparam logic [9:0] OP_ST_H = 10'h0a5;
  localparam logic [9:0] OP_ST_W = 10'h0a6;
  localparam logic [9:0] OP_LD_BU = 10'h0a8;
  localparam logic [9:0] OP_LD_HU = 10'h0a9;
  localparam logic [6:0] OP_LU12I_W = 7'h0a;
  localparam logic [6:0] OP_PCADDU12I = 7'h0e;
  localparam logic [5:0] OP_JIRL = 6'h13;
  localparam logic [5:0] OP_B = 6'h14;
  localparam logic [5:0] OP_BL = 6'h15;
  localparam logic [5:0] OP_BEQ = 6'h16;
  localparam logic [5:0] OP_BNE = 6'h17;
  localparam logic [5:0] OP_BLT = 6'h18;
  localparam logic [5:0] OP_BGE = 6'h19;
  localparam logic [5:0] OP_BLTU = 6'h1a;
  localparam logic [5:0] OP_BGEU = 6'h1b;
  typedef enum logic [3:0] {
    BR_NONE, BR_B, BR_BL, BR_JIRL, BR_BEQ, BR_BNE, BR_BLT, BR_BGE, BR_BLTU, BR_BGEU
  } br_kind_e;
  typedef struct packed {
    logic ok;
    logic [XLEN-1:0] val;
  } opnd_t;
endpackage

// File: rtl/id_buf_stage_decoder.sv
// id_decoder: combinational instruction decode to operand use flags, branch kind and immediate
module id_decoder
  import id_pkg::*;
(
  input  logic [31:0] inst,
  output logic        use1,
  output logic        use2,
  output logic        rs2_is_rd,
  output br_kind_e    br_kind,
  output logic [31:0] imm
);
  logic [16:0] op17;
  logic [9:0] op10;
  logic [6:0] op7;
  logic [5:0] op6;
  logic [31:0] si12, ui12, ui5, si20, offs16, offs26;
  assign op17 = inst[31:15];
  assign op10 = inst[31:22];
  assign op7 = inst[31:25];
  assign op6 = inst[31:26];
  assign ui5 = {27'b0, inst[14:10]};
  assign si12 = {{20{inst[21]}}, inst[21:10]};
  assign ui12 = {20'b0, inst[21:10]};
  assign si20 = {inst[24:5], 12'b0};
  assign offs16 = {{14{inst[25]}}, inst[25:10], 2'b0};
  assign offs26 = {{4{inst[9]}}, inst[9:0], inst[25:10], 2'b0};
  // classify the instruction by its opcode field
  always_comb begin
    use1 = 1'b0;
    use2 = 1'b0;
    rs2_is_rd = 1'b0;
    br_kind = BR_NONE;
    imm = '0;
    if (op17 inside {OP_ADD_W, OP_SUB_W, OP_SLT, OP_SLTU, OP_NOR, OP_AND, OP_OR, OP_XOR,
                     OP_SLL_W, OP_SRL_W, OP_SRA_W, OP_MUL_W, OP_MULH_W, OP_MULH_WU,
                     OP_DIV_W, OP_MOD_W, OP_DIV_WU, OP_MOD_WU}) begin
      use1 = 1'b1;
      use2 = 1'b1;
    end else if (op17 inside {OP_SLLI_W, OP_SRLI_W, OP_SRAI_W}) begin
      use1 = 1'b1;
      imm = ui5;
    end else if (op10 inside {OP_SLTI, OP_SLTUI, OP_ADDI_W, OP_LD_B, OP_LD_H, OP_LD_W,
                              OP_LD_BU, OP_LD_HU}) begin
      use1 = 1'b1;
      imm = si12;
    end else if (op10 inside {OP_ANDI, OP_ORI, OP_XORI}) begin
      use1 = 1'b1;
      imm = ui12;
    end else if (op10 inside {OP_ST_B, OP_ST_H, OP_ST_W}) begin
      use1 = 1'b1;
      use2 = 1'b1;
      rs2_is_rd = 1'b1;
      imm = si12;
    end else if (op7 inside {OP_LU12I_W, OP_PCADDU12I}) begin
      imm = si20;
    end else if (op6 == OP_JIRL) begin
      use1 = 1'b1;
      br_kind = BR_JIRL;
      imm = offs16;
    end else if (op6 inside {OP_B, OP_BL}) begin
      br_kind = op6 == OP_B ? BR_B : BR_BL;
      imm = offs26;
    end else if (op6 inside {OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU}) begin
      use1 = 1'b1;
      use2 = 1'b1;
      rs2_is_rd = 1'b1;
      imm = offs16;
      br_kind = op6 == OP_BEQ ? BR_BEQ :
                op6 == OP_BNE ? BR_BNE :
                op6 == OP_BLT ? BR_BLT :
                op6 == OP_BGE ? BR_BGE :
                op6 == OP_BLTU ? BR_BLTU : BR_BGEU;
    end
  end
endmodule

// File: rtl/id_buf_stage.sv
// id_buf_stage: buffered decode stage with prioritised bypass, branch resolution and stall counting
module id_buf_stage
  import id_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int NUM_FWD = 3,
  parameter int CNT_W = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [IF_TO_ID_W-1:0]         in_bus,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [31:0]                   out_pc,
  output logic [31:0]                   out_inst,
  output logic [31:0]                   out_rj_val,
  output logic [31:0]                   out_rk_val,
  output logic [4:0]                    rf_raddr1,
  output logic [4:0]                    rf_raddr2,
  input  logic [31:0]                   rf_rdata1,
  input  logic [31:0]                   rf_rdata2,
  input  logic [NUM_FWD-1:0]            fwd_valid,
  input  logic [NUM_FWD-1:0]            fwd_ready,
  input  logic [FWD_RD_W*NUM_FWD-1:0]   fwd_rd,
  input  logic [FWD_DATA_W*NUM_FWD-1:0] fwd_data,
  input  logic                          flush,
  output logic                          redirect,
  output logic [31:0]                   redirect_pc,
  output logic                          bp_upd_en,
  output logic [BP_UPD_W-1:0]           bp_upd_bus,
  output logic [CNT_W-1:0]              stall_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [IF_TO_ID_W-1:0] mem_q [DEPTH];
  logic [IF_TO_ID_W-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [IF_TO_ID_W-1:0] head;
  logic [31:0] head_pc, head_npc, head_inst, imm, rj, rk, target, actual_next;
  logic unused_pred_taken;
  logic use1, use2, rs2_is_rd, head_valid, hazard, fire, push, kill, taken, is_branch, is_cond;
  br_kind_e br_kind;
  opnd_t op1, op2;

  // lowest-index matching source wins; r0 and unused operands never stall
  function automatic opnd_t resolve(input logic use_f, input logic [REG_W-1:0] addr,
                                    input logic [XLEN-1:0] rf_val,
                                    input logic [NUM_FWD-1:0] vld, input logic [NUM_FWD-1:0] rdy,
                                    input logic [FWD_RD_W*NUM_FWD-1:0] rds,
                                    input logic [FWD_DATA_W*NUM_FWD-1:0] dat);
    opnd_t r;
    r.ok = 1'b1;
    r.val = (use_f && addr != '0) ? rf_val : '0;
    if (use_f && addr != '0)
      for (int i = NUM_FWD - 1; i >= 0; i--)
        if (vld[i] && rds[i*FWD_RD_W +: FWD_RD_W] == addr) begin
          r.ok = rdy[i];
          r.val = dat[i*FWD_DATA_W +: FWD_DATA_W];
        end
    return r;
  endfunction

  assign head = mem_q[rd_ptr_q];
  assign head_inst = head[IB_INST_LSB +: 32];
  assign head_pc = head[IB_PC_LSB +: 32];
  assign head_npc = head[IB_NPC_LSB +: 32];
  assign unused_pred_taken = head[IB_PRED_TAKEN];

  id_decoder u_dec (
    .inst      (head_inst),
    .use1      (use1),
    .use2      (use2),
    .rs2_is_rd (rs2_is_rd),
    .br_kind   (br_kind),
    .imm       (imm)
  );

  assign rf_raddr1 = head_inst[9:5];
  assign rf_raddr2 = rs2_is_rd ? head_inst[4:0] : head_inst[14:10];
  assign op1 = resolve(use1, rf_raddr1, rf_rdata1, fwd_valid, fwd_ready, fwd_rd, fwd_data);
  assign op2 = resolve(use2, rf_raddr2, rf_rdata2, fwd_valid, fwd_ready, fwd_rd, fwd_data);
  assign rj = op1.val;
  assign rk = op2.val;

  assign head_valid = count_q != '0;
  assign hazard = head_valid && !(op1.ok && op2.ok);
  assign in_ready = count_q != CW'(DEPTH);
  assign out_valid = head_valid && !hazard;
  assign fire = out_valid && out_ready;
  assign push = in_valid && in_ready;
  assign out_pc = head_pc;
  assign out_inst = head_inst;
  assign out_rj_val = rj;
  assign out_rk_val = rk;

  // resolve the head branch against the IF prediction
  always_comb begin
    is_branch = br_kind != BR_NONE;
    is_cond = br_kind inside {BR_BEQ, BR_BNE, BR_BLT, BR_BGE, BR_BLTU, BR_BGEU};
    target = br_kind == BR_JIRL ? rj + imm : head_pc + imm;
    taken = br_kind inside {BR_B, BR_BL, BR_JIRL} ? 1'b1 :
            br_kind == BR_BEQ ? rj == rk :
            br_kind == BR_BNE ? rj != rk :
            br_kind == BR_BLT ? $signed(rj) < $signed(rk) :
            br_kind == BR_BGE ? $signed(rj) >= $signed(rk) :
            br_kind == BR_BLTU ? rj < rk :
            br_kind == BR_BGEU ? rj >= rk : 1'b0;
    actual_next = taken ? target : head_pc + 32'd4;
  end

  assign redirect = fire && head_npc != actual_next;
  assign redirect_pc = actual_next;
  assign bp_upd_en = fire;
  assign bp_upd_bus = {head_pc, is_branch, is_cond, taken, target};
  assign stall_cnt = stall_cnt_q;
  assign kill = flush || redirect;

  // buffer pointers, occupancy and stall counter next state
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = in_bus;
    wr_ptr_d = kill ? '0 : push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = kill ? '0 : fire ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d = kill ? '0 : count_q + CW'(push) - CW'(fire);
    stall_cnt_d = (hazard && !(&stall_cnt_q)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
  end

  // state registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end
endmodule

// File: tb/tb_id_buf_stage.sv
// tb_id_buf_stage: directed self-checking bench for id_buf_stage
module tb_id_buf_stage;
  logic clk = 1'b0;
  logic reset, in_valid, in_ready, out_valid, out_ready, flush, redirect, bp_upd_en;
  logic [96:0] in_bus;
  logic [31:0] out_pc, out_inst, out_rj_val, out_rk_val, rf_rdata1, rf_rdata2, redirect_pc;
  logic [4:0] rf_raddr1, rf_raddr2;
  logic [2:0] fwd_valid, fwd_ready;
  logic [14:0] fwd_rd;
  logic [95:0] fwd_data;
  logic [66:0] bp_upd_bus;
  logic [31:0] stall_cnt;
  logic [31:0] regs [32];
  int tests = 0;
  int fails = 0;

  id_buf_stage #(.DEPTH(4), .NUM_FWD(3), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_bus(in_bus),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
    .out_rj_val(out_rj_val), .out_rk_val(out_rk_val), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .fwd_valid(fwd_valid), .fwd_ready(fwd_ready),
    .fwd_rd(fwd_rd), .fwd_data(fwd_data), .flush(flush), .redirect(redirect),
    .redirect_pc(redirect_pc), .bp_upd_en(bp_upd_en), .bp_upd_bus(bp_upd_bus), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;
  assign rf_rdata1 = regs[rf_raddr1];
  assign rf_rdata2 = regs[rf_raddr2];

  function automatic logic [31:0] enc_add(input logic [4:0] rd, input logic [4:0] rj, input logic [4:0] rk);
    return {17'h00020, rk, rj, rd};
  endfunction

  function automatic logic [31:0] enc_br(input logic [5:0] op, input logic [4:0] rj, input logic [4:0] rd, input logic [15:0] offs);
    return {op, offs, rj, rd};
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic push_now(input logic [31:0] pc, input logic [31:0] inst);
    in_valid = 1'b1;
    in_bus = {1'b0, pc + 32'd4, pc, inst};
    step;
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    #2;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %0b expected 1", in_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
    tests++; if ({redirect, bp_upd_en} !== 2'b00) begin fails++; $display("FAIL reset_redirect_upd: got %b expected 00", {redirect, bp_upd_en}); end
    tests++; if (stall_cnt !== 32'd0) begin fails++; $display("FAIL reset_stall_cnt: got %0d expected 0", stall_cnt); end
    step;
    step;
    reset = 1'b1;
    step;
  endtask

  task automatic test_fill_drain;
    logic [31:0] pc;
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      pc = 32'h1c000000 + 32'(4 * k);
      in_valid = 1'b1;
      in_bus = {1'b0, pc + 32'd4, pc, enc_add(5'd3, 5'd1, 5'd2)};
      #1;
      tests++; if (in_ready !== (k < 4)) begin fails++; $display("FAIL fill_in_ready_%0d: got %0b expected %0b", k, in_ready, k < 4); end
      if (k == 1) begin
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL fill_latency: got out_valid %0b expected 1", out_valid); end
        tests++; if ({out_rj_val, out_rk_val} !== {32'h11, 32'h22}) begin fails++; $display("FAIL fill_operands: got %h %h expected 11 22", out_rj_val, out_rk_val); end
      end
      step;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      pc = 32'h1c000000 + 32'(4 * j);
      tests++; if ({out_valid, out_pc, redirect} !== {1'b1, pc, 1'b0}) begin fails++; $display("FAIL drain_%0d: got valid %0b pc %h redirect %0b expected 1 %h 0", j, out_valid, out_pc, redirect, pc); end
      step;
    end
    out_ready = 1'b0;
    tests++; if ({out_valid, in_ready} !== 2'b01) begin fails++; $display("FAIL drain_empty: got valid/ready %b expected 01", {out_valid, in_ready}); end
  endtask

  task automatic test_bypass;
    push_now(32'h200, enc_add(5'd3, 5'd1, 5'd2));
    fwd_valid = 3'b101;
    fwd_ready = 3'b111;
    fwd_rd = {5'd1, 5'd0, 5'd1};
    fwd_data = {32'hBBBB, 32'h0, 32'hAAAA};
    #1;
    tests++; if ({out_valid, out_rj_val, out_rk_val} !== {1'b1, 32'hAAAA, 32'h22}) begin fails++; $display("FAIL bypass_priority: got %0b %h %h expected 1 0000aaaa 00000022", out_valid, out_rj_val, out_rk_val); end
    fwd_ready = 3'b110;
    #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bypass_load_stall: got out_valid %0b expected 0", out_valid); end
    step;
    tests++; if (stall_cnt !== 32'd1) begin fails++; $display("FAIL stall_cnt_1: got %0d expected 1", stall_cnt); end
    step;
    tests++; if (stall_cnt !== 32'd2) begin fails++; $display("FAIL stall_cnt_2: got %0d expected 2", stall_cnt); end
    fwd_ready = 3'b111;
    fwd_data = {32'hBBBB, 32'h0, 32'h55};
    #1;
    tests++; if ({out_valid, out_rj_val} !== {1'b1, 32'h55}) begin fails++; $display("FAIL bypass_ready: got %0b %h expected 1 00000055", out_valid, out_rj_val); end
    out_ready = 1'b1;
    step;
    out_ready = 1'b0;
    fwd_valid = 3'b000;
  endtask

  task automatic test_r0;
    push_now(32'h300, enc_add(5'd3, 5'd0, 5'd2));
    fwd_valid = 3'b001;
    fwd_ready = 3'b000;
    fwd_rd = 15'd0;
    fwd_data = {64'h0, 32'hDEAD};
    #1;
    tests++; if ({out_valid, out_rj_val, out_rk_val} !== {1'b1, 32'h0, 32'h22}) begin fails++; $display("FAIL r0_guard: got %0b %h %h expected 1 00000000 00000022", out_valid, out_rj_val, out_rk_val); end
    step;
    tests++; if (stall_cnt !== 32'd2) begin fails++; $display("FAIL r0_no_stall: got %0d expected 2", stall_cnt); end
    out_ready = 1'b1;
    step;
    out_ready = 1'b0;
    fwd_valid = 3'b000;
  endtask

  task automatic test_branch;
    push_now(32'h100, enc_br(6'h1a, 5'd4, 5'd5, 16'h0010));
    push_now(32'h104, enc_add(5'd3, 5'd1, 5'd2));
    out_ready = 1'b1;
    #1;
    tests++; if ({out_valid, out_rj_val, out_rk_val} !== {1'b1, 32'hFFFFFFFF, 32'h1}) begin fails++; $display("FAIL bltu_operands: got %0b %h %h expected 1 ffffffff 00000001", out_valid, out_rj_val, out_rk_val); end
    tests++; if ({redirect, bp_upd_en, redirect_pc} !== {2'b01, 32'h104}) begin fails++; $display("FAIL bltu_not_taken: got redirect %0b upd %0b pc %h expected 0 1 00000104", redirect, bp_upd_en, redirect_pc); end
    tests++; if (bp_upd_bus !== {32'h100, 1'b1, 1'b1, 1'b0, 32'h140}) begin fails++; $display("FAIL bltu_bp_upd: got %h expected %h", bp_upd_bus, {32'h100, 1'b1, 1'b1, 1'b0, 32'h140}); end
    step;
    tests++; if ({out_valid, out_pc} !== {1'b1, 32'h104}) begin fails++; $display("FAIL bltu_younger_kept: got %0b %h expected 1 00000104", out_valid, out_pc); end
    step;
    out_ready = 1'b0;
    push_now(32'h100, enc_br(6'h18, 5'd4, 5'd5, 16'h0010));
    push_now(32'h104, enc_add(5'd3, 5'd1, 5'd2));
    push_now(32'h108, enc_add(5'd3, 5'd1, 5'd2));
    out_ready = 1'b1;
    #1;
    tests++; if ({redirect, redirect_pc} !== {1'b1, 32'h140}) begin fails++; $display("FAIL blt_redirect: got %0b %h expected 1 00000140", redirect, redirect_pc); end
    tests++; if (bp_upd_bus !== {32'h100, 1'b1, 1'b1, 1'b1, 32'h140}) begin fails++; $display("FAIL blt_bp_upd: got %h expected %h", bp_upd_bus, {32'h100, 1'b1, 1'b1, 1'b1, 32'h140}); end
    step;
    out_ready = 1'b0;
    tests++; if ({out_valid, in_ready} !== 2'b01) begin fails++; $display("FAIL blt_younger_dropped: got valid/ready %b expected 01", {out_valid, in_ready}); end
  endtask

  task automatic test_flush;
    push_now(32'h400, enc_add(5'd3, 5'd1, 5'd2));
    push_now(32'h404, enc_add(5'd3, 5'd1, 5'd2));
    push_now(32'h408, enc_add(5'd3, 5'd1, 5'd2));
    in_valid = 1'b1;
    in_bus = {1'b0, 32'h410, 32'h40c, enc_add(5'd3, 5'd1, 5'd2)};
    flush = 1'b1;
    step;
    in_valid = 1'b0;
    flush = 1'b0;
    tests++; if ({out_valid, in_ready} !== 2'b01) begin fails++; $display("FAIL flush_empty: got valid/ready %b expected 01", {out_valid, in_ready}); end
    push_now(32'h500, enc_add(5'd3, 5'd1, 5'd2));
    tests++; if ({out_valid, out_pc} !== {1'b1, 32'h500}) begin fails++; $display("FAIL flush_refill: got %0b %h expected 1 00000500", out_valid, out_pc); end
    out_ready = 1'b1;
    step;
    out_ready = 1'b0;
  endtask

  task automatic test_async_reset;
    push_now(32'h600, enc_add(5'd3, 5'd1, 5'd2));
    fwd_valid = 3'b001;
    fwd_ready = 3'b000;
    fwd_rd = {10'd0, 5'd1};
    fwd_data = {64'h0, 32'h77};
    step;
    step;
    step;
    tests++; if ({out_valid, stall_cnt} !== {1'b0, 32'd5}) begin fails++; $display("FAIL async_pre_stall: got %0b %0d expected 0 5", out_valid, stall_cnt); end
    fwd_ready = 3'b001;
    #1;
    tests++; if ({out_valid, out_rj_val} !== {1'b1, 32'h77}) begin fails++; $display("FAIL async_pre_valid: got %0b %h expected 1 00000077", out_valid, out_rj_val); end
    #1;
    reset = 1'b0;
    #1;
    tests++; if ({out_valid, stall_cnt, in_ready} !== {1'b0, 32'd0, 1'b1}) begin fails++; $display("FAIL async_reset: got valid %0b cnt %0d ready %0b expected 0 0 1", out_valid, stall_cnt, in_ready); end
    fwd_valid = 3'b000;
    step;
    reset = 1'b1;
    step;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'h1000 + 32'(i);
    regs[0] = 32'h0;
    regs[1] = 32'h11;
    regs[2] = 32'h22;
    regs[4] = 32'hFFFFFFFF;
    regs[5] = 32'h1;
    in_valid = 1'b0;
    in_bus = '0;
    out_ready = 1'b0;
    flush = 1'b0;
    fwd_valid = '0;
    fwd_ready = '0;
    fwd_rd = '0;
    fwd_data = '0;
    test_reset;
    test_fill_drain;
    test_bypass;
    test_r0;
    test_branch;
    test_flush;
    test_async_reset;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
